// File: rtl/hazard_sb_pkg.sv
// hazard_sb_pkg: shared defaults and mult/div helpers for the hazard scoreboard.
// Imported by hazard_sb; optional perf counters enabled with `HAZARD_PERF_EN.
package hazard_sb_pkg;

  localparam int HZ_DW        = 32;
  localparam int HZ_AW        = 5;
  localparam int HZ_TW        = 3;
  localparam int HZ_NSRC      = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  function automatic int md_lat(
    input md_op_e op,
    input int     mult_lat,
    input int     div_lat
  );
    return (op == MD_DIV) ? div_lat : mult_lat;
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// hazard_fwd_mux: picks forward data for one operand.
// Source 0 has highest priority; address 0 always reads as zero.
module hazard_fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int N  = 1
) (
  input  logic [AW-1:0]   a,
  input  logic [DW-1:0]   lat,
  input  logic [N*AW-1:0] src_ad,
  input  logic [N*DW-1:0] src_wd,
  output logic [DW-1:0]   m
);

  always_comb begin
    m = lat;
    for (int s = N - 1; s >= 0; s--) begin
      if (src_ad[s*AW +: AW] == a)
        m = src_wd[s*DW +: DW];
    end
    if (a == '0)
      m = '0;
  end

endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: forwarding, Tuse/Tnew stall and mult/div busy tracking.
// Define `HAZARD_PERF_EN to build the stall performance counters.
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int DW       = HZ_DW,
  parameter int AW       = HZ_AW,
  parameter int TW       = HZ_TW,
  parameter int NSRC     = HZ_NSRC,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC*AW-1:0] D_a,
  input  logic [NSRC*TW-1:0] D_tuse,
  input  logic [NSRC*DW-1:0] D_o,
  input  logic [NSRC*AW-1:0] E_a,
  input  logic [NSRC*DW-1:0] E_o,
  input  logic [AW-1:0]     M_a,
  input  logic [DW-1:0]     M_o,
  input  logic [AW-1:0]     E_ad,
  input  logic [AW-1:0]     M_ad,
  input  logic [AW-1:0]     W_ad,
  input  logic [TW-1:0]     E_tnew,
  input  logic [TW-1:0]     M_tnew,
  input  logic [DW-1:0]     E_wd,
  input  logic [DW-1:0]     M_wd,
  input  logic [DW-1:0]     W_wd,
  input  logic              E_md_start,
  input  logic              E_md_div,
  input  logic              D_md_use,
  output logic [NSRC*DW-1:0] D_m,
  output logic [NSRC*DW-1:0] E_m,
  output logic [DW-1:0]     M_m,
  output logic              stall,
  output logic              md_busy,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_md_stall
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [NSRC-1:0] op_stall;
  logic            md_stall;
  logic [CW-1:0]   md_cnt;
  md_op_e          md_op;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    logic [AW-1:0] da;
    logic [TW-1:0] tu;

    assign da = D_a[i*AW +: AW];
    assign tu = D_tuse[i*TW +: TW];

    hazard_fwd_mux #(.DW(DW), .AW(AW), .N(3)) u_d_fwd (
      .a      (da),
      .lat    (D_o[i*DW +: DW]),
      .src_ad ({W_ad, M_ad, E_ad}),
      .src_wd ({W_wd, M_wd, E_wd}),
      .m      (D_m[i*DW +: DW])
    );

    hazard_fwd_mux #(.DW(DW), .AW(AW), .N(2)) u_e_fwd (
      .a      (E_a[i*AW +: AW]),
      .lat    (E_o[i*DW +: DW]),
      .src_ad ({W_ad, M_ad}),
      .src_wd ({W_wd, M_wd}),
      .m      (E_m[i*DW +: DW])
    );

    assign op_stall[i] = (da != '0) &&
      (((da == E_ad) && (tu < E_tnew)) ||
       ((da == M_ad) && (tu < M_tnew)));
  end

  hazard_fwd_mux #(.DW(DW), .AW(AW), .N(1)) u_m_fwd (
    .a      (M_a),
    .lat    (M_o),
    .src_ad (W_ad),
    .src_wd (W_wd),
    .m      (M_m)
  );

  assign md_op = md_op_e'(E_md_div);

  // A start while busy is dropped; the stall should make it impossible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else begin
      assert (!(E_md_start && (md_cnt != '0)))
        else $error("hazard_sb: mult/div start while busy");
      if (E_md_start && (md_cnt == '0))
        md_cnt <= CW'(md_lat(md_op, MULT_LAT, DIV_LAT));
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = D_md_use && (md_busy || E_md_start);
  assign stall    = (|op_stall) || md_stall;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall    <= '0;
      perf_md_stall <= '0;
    end else begin
      if (stall && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
      if (md_stall && (perf_md_stall != '1))
        perf_md_stall <= perf_md_stall + 32'd1;
    end
  end
`else
  assign perf_stall    = '0;
  assign perf_md_stall = '0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: directed vectors with a per-cycle reference model.
// Honours `HAZARD_PERF_EN for the perf counter expectations.
module tb_hazard_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int TW   = 3;
  localparam int NSRC = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC*AW-1:0] D_a, E_a;
  logic [NSRC*TW-1:0] D_tuse;
  logic [NSRC*DW-1:0] D_o, E_o;
  logic [AW-1:0]     M_a, E_ad, M_ad, W_ad;
  logic [DW-1:0]     M_o, E_wd, M_wd, W_wd;
  logic [TW-1:0]     E_tnew, M_tnew;
  logic              E_md_start, E_md_div, D_md_use;
  logic [NSRC*DW-1:0] D_m, E_m;
  logic [DW-1:0]     M_m;
  logic              stall, md_busy;
  logic [31:0]       perf_stall, perf_md_stall;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          busy_end = 0;
  logic [31:0] ep_s = 0;
  logic [31:0] ep_m = 0;

  hazard_sb #(
    .DW(DW), .AW(AW), .TW(TW), .NSRC(NSRC),
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .D_a(D_a), .D_tuse(D_tuse), .D_o(D_o),
    .E_a(E_a), .E_o(E_o), .M_a(M_a), .M_o(M_o),
    .E_ad(E_ad), .M_ad(M_ad), .W_ad(W_ad),
    .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_wd(E_wd), .M_wd(M_wd), .W_wd(W_wd),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .D_md_use(D_md_use),
    .D_m(D_m), .E_m(E_m), .M_m(M_m),
    .stall(stall), .md_busy(md_busy),
    .perf_stall(perf_stall), .perf_md_stall(perf_md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Nearest producer at or after stage 'first' (0=E,1=M,2=W) wins.
  function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] a,
                                          input logic [DW-1:0] lat,
                                          input int first);
    logic [AW-1:0] ad [3];
    logic [DW-1:0] wd [3];
    ad[0] = E_ad; ad[1] = M_ad; ad[2] = W_ad;
    wd[0] = E_wd; wd[1] = M_wd; wd[2] = W_wd;
    if (a == 0) return '0;
    for (int s = first; s < 3; s++)
      if (a == ad[s]) return wd[s];
    return lat;
  endfunction

  function automatic bit m_opstall();
    bit r = 0;
    for (int i = 0; i < NSRC; i++) begin
      int a = int'(D_a[i*AW +: AW]);
      int t = int'(D_tuse[i*TW +: TW]);
      if (a != 0) begin
        if (a == int'(E_ad) && int'(E_tnew) > t) r = 1;
        if (a == int'(M_ad) && int'(M_tnew) > t) r = 1;
      end
    end
    return r;
  endfunction

  function automatic bit m_busy();
    return rst_n && (cyc < busy_end);
  endfunction

  function automatic bit m_mdstall();
    return D_md_use && (m_busy() || E_md_start);
  endfunction

  // Reference model state advances on each rising edge.
  initial forever begin
    bit st, ms, b;
    @(posedge clk);
    b  = m_busy();
    st = m_opstall() || m_mdstall();
    ms = m_mdstall();
    if (!rst_n) begin
      busy_end = 0;
      ep_s = 0;
      ep_m = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (st && ep_s != 32'hFFFF_FFFF) ep_s = ep_s + 1;
      if (ms && ep_m != 32'hFFFF_FFFF) ep_m = ep_m + 1;
`endif
      if (E_md_start && !b)
        busy_end = cyc + 1 + (E_md_div ? DIV_LAT : MULT_LAT);
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NSRC; i++) begin
      chk($sformatf("D_m[%0d]", i), D_m[i*DW +: DW],
          m_fwd(D_a[i*AW +: AW], D_o[i*DW +: DW], 0));
      chk($sformatf("E_m[%0d]", i), E_m[i*DW +: DW],
          m_fwd(E_a[i*AW +: AW], E_o[i*DW +: DW], 1));
    end
    chk("M_m", M_m, m_fwd(M_a, M_o, 2));
    chk("stall", {31'd0, stall}, {31'd0, m_opstall() || m_mdstall()});
    chk("md_busy", {31'd0, md_busy}, {31'd0, m_busy()});
    chk("perf_stall", perf_stall, ep_s);
    chk("perf_md_stall", perf_md_stall, ep_m);
  end

  task automatic clr();
    D_a = '0; E_a = '0; D_tuse = '0;
    D_o = {32'h0D00_0001, 32'h0D00_0000};
    E_o = {32'h0E00_0001, 32'h0E00_0000};
    M_a = '0; M_o = 32'h0A00_0000;
    E_ad = '0; M_ad = '0; W_ad = '0;
    E_tnew = '0; M_tnew = '0;
    E_wd = 32'h1111_0000; M_wd = 32'h2222_0000; W_wd = 32'h3333_0000;
    E_md_start = 0; E_md_div = 0; D_md_use = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    clr();
    @(negedge clk);
    chk("rst md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst perf", perf_stall, 32'd0);
    nxt();
    rst_n = 1;

    E_ad = 8; E_tnew = 1; D_a[AW-1:0] = 8; D_tuse = '0;
    @(negedge clk);
    chk("tnew stall", {31'd0, stall}, 32'd1);
    nxt();
    E_ad = 0; E_tnew = 0; M_ad = 8; M_tnew = 0; M_wd = 32'h0000_1234;
    @(negedge clk);
    chk("m ready stall", {31'd0, stall}, 32'd0);
    chk("m fwd", D_m[DW-1:0], 32'h0000_1234);

    nxt(); clr();
    E_ad = 9; M_ad = 9; W_ad = 9;
    E_wd = 1; M_wd = 2; W_wd = 3;
    D_a[2*AW-1:AW] = 9; E_a[2*AW-1:AW] = 9; M_a = 9;
    @(negedge clk);
    chk("D prio", D_m[2*DW-1:DW], 32'd1);
    chk("E prio", E_m[2*DW-1:DW], 32'd2);
    chk("M prio", M_m, 32'd3);

    nxt(); clr();
    D_o[DW-1:0] = 32'h0000_DEAD;
    @(negedge clk);
    chk("zero reg", D_m[DW-1:0], 32'd0);
    chk("zero stall", {31'd0, stall}, 32'd0);
    nxt();
    D_a[AW-1:0] = 5;
    @(negedge clk);
    chk("no match", D_m[DW-1:0], 32'h0000_DEAD);

    nxt(); clr();
    E_ad = 4; E_tnew = 2; D_a[2*AW-1:AW] = 4; D_tuse[2*TW-1:TW] = 2;
    @(negedge clk);
    chk("tuse==tnew", {31'd0, stall}, 32'd0);
    nxt();
    D_tuse[2*TW-1:TW] = 1;
    @(negedge clk);
    chk("tuse<tnew", {31'd0, stall}, 32'd1);
    nxt(); clr();
    M_ad = 7; M_tnew = 1; D_a[AW-1:0] = 7;
    @(negedge clk);
    chk("m tnew stall", {31'd0, stall}, 32'd1);
    nxt(); clr();
    W_ad = 6; D_a[AW-1:0] = 6; W_wd = 32'h0000_0066;
    @(negedge clk);
    chk("w no stall", {31'd0, stall}, 32'd0);
    chk("w fwd", D_m[DW-1:0], 32'h0000_0066);

    nxt(); clr();
    E_md_start = 1; E_md_div = 1; D_md_use = 1;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) begin
        nxt();
        if (k == 1) begin E_md_start = 0; E_md_div = 0; end
      end
      @(negedge clk);
      chk($sformatf("div stall c%0d", k), {31'd0, stall},
          (k <= 10) ? 32'd1 : 32'd0);
    end
    chk("div done busy", {31'd0, md_busy}, 32'd0);

    nxt(); clr();
    E_md_start = 1;
    nxt();
    E_md_start = 0;
    @(negedge clk);
    chk("mult busy", {31'd0, md_busy}, 32'd1);
    nxt();
    rst_n = 0;
    #1;
    chk("async drop", {31'd0, md_busy}, 32'd0);
    nxt();
    rst_n = 1;
    @(negedge clk);
    chk("post rst busy", {31'd0, md_busy}, 32'd0);
    nxt();
    @(negedge clk);
    chk("post rst busy2", {31'd0, md_busy}, 32'd0);

    nxt();
    rst_n = 0;
    nxt();
    rst_n = 1;
    E_ad = 8; E_tnew = 1; D_a[AW-1:0] = 8;
    nxt(); clr();
    E_md_start = 1; D_md_use = 1;
    nxt();
    E_md_start = 0;
    nxt();
    D_md_use = 0;
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_stall lit", perf_stall, 32'd3);
    chk("perf_md lit", perf_md_stall, 32'd2);
`else
    chk("perf_stall lit", perf_stall, 32'd0);
    chk("perf_md lit", perf_md_stall, 32'd0);
`endif

    repeat (6) nxt();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
